// File: rtl/adc_sar_control.sv
// 12-bit successive-approximation ADC controller: sample, then resolve one bit
// per two cycles (settle/strobe, then decide) from MSB to LSB.
module adc_sar_control #(
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        comp_in,
    output logic        sample_o,
    output logic        comp_strobe_o,
    output logic [11:0] dac_p_o,
    output logic [11:0] dac_n_o,
    output logic [11:0] result_o,
    output logic        valid_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SAMPLE_CYCLES - 1);

    state_t      state_r;
    logic [11:0] trial_r;
    logic [3:0]  k_r;
    logic        ph_r;
    logic [3:0]  cnt_r;
    logic [11:0] result_r;
    logic        valid_r;
    logic        busy_r;
    logic        sample_r;
    logic        strobe_r;
    logic [11:0] decided_s;

    // Trial code with the bit under test resolved by the comparator.
    always_comb begin
        decided_s = trial_r;
        if (comp_in) begin
            decided_s = trial_r & ~(12'd1 << k_r);
        end else begin
            decided_s = trial_r;
        end
    end

    // Conversion sequencer; every output is a register updated on transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            trial_r  <= 12'h800;
            k_r      <= 4'd0;
            ph_r     <= 1'b0;
            cnt_r    <= 4'd0;
            result_r <= 12'h000;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            sample_r <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (start_i) begin
                        state_r  <= ST_SAMPLE;
                        trial_r  <= 12'h800;
                        cnt_r    <= CNT_INIT;
                        busy_r   <= 1'b1;
                        sample_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_r == 4'd0) begin
                        state_r  <= ST_CONV;
                        k_r      <= 4'd11;
                        ph_r     <= 1'b0;
                        sample_r <= 1'b0;
                        strobe_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_CONV: begin
                    if (!ph_r) begin
                        ph_r     <= 1'b1;
                        strobe_r <= 1'b0;
                    end else if (k_r != 4'd0) begin
                        // Next bit is raised in the same edge so it settles for a full cycle.
                        trial_r  <= decided_s | (12'd1 << (k_r - 4'd1));
                        k_r      <= k_r - 4'd1;
                        ph_r     <= 1'b0;
                        strobe_r <= 1'b1;
                    end else begin
                        trial_r  <= decided_s;
                        result_r <= decided_s;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    sample_r <= 1'b0;
                    strobe_r <= 1'b0;
                end
            endcase
        end
    end

    assign sample_o      = sample_r;
    assign comp_strobe_o = strobe_r;
    assign dac_p_o       = trial_r;
    assign dac_n_o       = ~trial_r;
    assign result_o      = result_r;
    assign valid_o       = valid_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_adc_sar_control.sv
// Self-checking bench: three controllers (S=4, 1, 15) driven by an ideal comparator
// against a threshold; expectations come from binary-search arithmetic on that threshold.
module tb_adc_sar_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  tie1;
    logic [2:0]  tie0;
    logic [11:0] thr [3];
    logic [2:0]  comp;
    logic [2:0]  sample;
    logic [2:0]  strobe;
    logic [2:0]  valid;
    logic [2:0]  busy;
    logic [11:0] dac_p [3];
    logic [11:0] dac_n [3];
    logic [11:0] result [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_cmp
        assign comp[g] = tie1[g] | (~tie0[g] & (dac_p[g] > thr[g]));
    end

    adc_sar_control #(.SAMPLE_CYCLES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .comp_in(comp[0]),
        .sample_o(sample[0]), .comp_strobe_o(strobe[0]), .dac_p_o(dac_p[0]),
        .dac_n_o(dac_n[0]), .result_o(result[0]), .valid_o(valid[0]), .busy_o(busy[0]));
    adc_sar_control #(.SAMPLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .comp_in(comp[1]),
        .sample_o(sample[1]), .comp_strobe_o(strobe[1]), .dac_p_o(dac_p[1]),
        .dac_n_o(dac_n[1]), .result_o(result[1]), .valid_o(valid[1]), .busy_o(busy[1]));
    adc_sar_control #(.SAMPLE_CYCLES(15)) u_s15 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .comp_in(comp[2]),
        .sample_o(sample[2]), .comp_strobe_o(strobe[2]), .dac_p_o(dac_p[2]),
        .dac_n_o(dac_n[2]), .result_o(result[2]), .valid_o(valid[2]), .busy_o(busy[2]));

    function automatic int s_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 1 : 15;
    endfunction

    // Binary search toward v: bits above step j already equal v, bit (11-j) on trial.
    function automatic logic [11:0] exp_trial(input logic [11:0] v, input int j);
        logic [11:0] m;
        logic [11:0] b;
        m = 12'hFFF;
        m = m << (12 - j);
        b = 12'h800;
        b = b >> j;
        return (v & m) | b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: threshold comparator, 1: comp tied 1, 2: comp tied 0.
    task automatic run_conv(input int idx, input logic [11:0] th, input int mode,
                            input bit noise, input string name);
        int s = s_of(idx);
        logic [11:0] eff;
        int samp = 0, strb = 0, inv_bad = 0, seq_bad = 0, vcnt = 0, vat = -1, bfall = -1;
        logic [11:0] got = 12'h000;
        eff = (mode == 1) ? 12'h000 : (mode == 2) ? 12'hFFF : th;
        thr[idx] = th;
        tie1[idx] = (mode == 1);
        tie0[idx] = (mode == 2);
        start[idx] = 1'b1;
        tick();
        start[idx] = 1'b0;
        for (int n = 0; n < s + 40; n++) begin
            if (sample[idx]) samp++;
            if (dac_n[idx] !== ~dac_p[idx]) inv_bad++;
            if (strobe[idx]) begin
                if (dac_p[idx] !== exp_trial(eff, strb)) seq_bad++;
                strb++;
            end
            if (valid[idx]) begin
                vcnt++;
                vat = n;
                got = result[idx];
            end
            if (busy[idx] !== 1'b1 && bfall < 0) bfall = n;
            start[idx] = noise && (n == 1 || n == s + 5);
            tick();
        end
        start[idx] = 1'b0;
        tests++; if (samp !== s) begin fails++; $display("FAIL %s sample_width got %0d want %0d", name, samp, s); end
        tests++; if (strb !== 12) begin fails++; $display("FAIL %s strobe_count got %0d want 12", name, strb); end
        tests++; if (inv_bad !== 0) begin fails++; $display("FAIL %s dac_n_inverse bad_cycles %0d want 0", name, inv_bad); end
        tests++; if (seq_bad !== 0) begin fails++; $display("FAIL %s trial_sequence bad_steps %0d want 0", name, seq_bad); end
        tests++; if (vcnt !== 1) begin fails++; $display("FAIL %s valid_count got %0d want 1", name, vcnt); end
        tests++; if (vat !== s + 24) begin fails++; $display("FAIL %s valid_cycle got %0d want %0d", name, vat, s + 24); end
        tests++; if (got !== eff) begin fails++; $display("FAIL %s result got %h want %h", name, got, eff); end
        tests++; if (bfall !== s + 25) begin fails++; $display("FAIL %s busy_fall got %0d want %0d", name, bfall, s + 25); end
        tests++; if (dac_n[idx] !== ~eff) begin fails++; $display("FAIL %s dac_n_hold got %h want %h", name, dac_n[idx], ~eff); end
        tie1[idx] = 1'b0;
        tie0[idx] = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({sample[i], strobe[i], valid[i], busy[i]} !== 4'b0000 || dac_p[i] !== 12'h800 ||
                dac_n[i] !== 12'h7FF || result[i] !== 12'h000) begin
                fails++;
                $display("FAIL %s inst%0d got s=%b st=%b v=%b b=%b p=%h n=%h r=%h want 0 0 0 0 800 7ff 000",
                         name, i, sample[i], strobe[i], valid[i], busy[i], dac_p[i], dac_n[i], result[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        check_reset_values("first_edge_idle");
    endtask

    task automatic test_spec_vectors();
        run_conv(0, 12'hA5C, 0, 1'b0, "a5c");
        run_conv(0, 12'h000, 1, 1'b0, "tied1");
        run_conv(0, 12'h000, 2, 1'b0, "tied0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_conv(0, 12'($urandom_range(0, 4095)), 0, 1'($urandom_range(0, 1)), "rand_s4");
        end
    endtask

    task automatic test_ignored_start();
        run_conv(0, 12'h3C7, 0, 1'b1, "start_ignored");
    endtask

    task automatic test_sample_cycles();
        run_conv(1, 12'($urandom_range(0, 4095)), 0, 1'b0, "s1");
        run_conv(2, 12'($urandom_range(0, 4095)), 0, 1'b0, "s15");
        run_conv(1, 12'hFFF, 0, 1'b0, "s1_full");
        run_conv(2, 12'h001, 0, 1'b0, "s15_one");
    endtask

    task automatic test_reset_mid();
        int strb = 0, vcnt = 0;
        bit hit = 1'b0;
        run_conv(0, 12'h5D3, 0, 1'b0, "pre_reset");
        thr[0] = 12'($urandom_range(0, 4095));
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            if (strobe[0]) strb++;
            if (strb == 6) hit = 1'b1;
            else tick();
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL reset_mid reach_bit6 got timeout want strobe 6"); end
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid");
        #3 rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (valid[0]) vcnt++;
        end
        tests++;
        if (vcnt !== 0) begin fails++; $display("FAIL reset_mid stray_valid got %0d want 0", vcnt); end
        run_conv(0, 12'h123, 0, 1'b0, "after_reset_123");
    endtask

    task automatic test_back_to_back();
        int at[$];
        int bad_res = 0, bad_gap = 0;
        logic [11:0] v;
        v = 12'($urandom_range(0, 4095));
        thr[0] = v;
        start[0] = 1'b1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (valid[0]) begin
                at.push_back(n);
                if (result[0] !== v) bad_res++;
            end
        end
        start[0] = 1'b0;
        repeat (40) tick();
        for (int i = 1; i < at.size(); i++) begin
            if (at[i] - at[i-1] != 30) bad_gap++;
        end
        tests++; if (at.size() !== 3) begin fails++; $display("FAIL b2b pulse_count got %0d want 3", at.size()); end
        tests++; if (bad_gap !== 0) begin fails++; $display("FAIL b2b period bad_gaps %0d want 0 (period 30)", bad_gap); end
        tests++; if (bad_res !== 0) begin fails++; $display("FAIL b2b result bad %0d want 0", bad_res); end
    endtask

    initial begin
        start = 3'b000;
        tie1 = 3'b000;
        tie0 = 3'b000;
        for (int i = 0; i < 3; i++) thr[i] = 12'h000;
        test_reset();
        test_spec_vectors();
        test_random();
        test_ignored_start();
        test_sample_cycles();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
